// File: rtl/psola_frame_sequencer.sv
// Frame sequencer for the PSOLA path: ping-pong sample bank fill counter plus
// the IDLE -> DETECT -> LAUNCH -> RUN control FSM with period validation.
module psola_frame_sequencer #(
  parameter int  WINDOW_SIZE    = 2048,
  parameter int  MIN_PERIOD     = 20,
  parameter int  MAX_PERIOD     = 1024,
  parameter int  DEFAULT_PERIOD = 200,
  parameter int  DETECT_TIMEOUT = 4096,
  localparam int AW             = $clog2(WINDOW_SIZE)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          sample_valid_in,
  output logic          wr_en_out,
  output logic          wr_bank_out,
  output logic [AW-1:0] wr_addr_out,
  output logic          detect_start_out,
  output logic          detect_bank_out,
  input  logic [11:0]   period_in,
  input  logic          period_valid_in,
  output logic          psola_start_out,
  output logic [11:0]   psola_period_out,
  input  logic          psola_done_in,
  output logic          busy_out,
  output logic          overrun_out,
  output logic          timeout_out,
  output logic [15:0]   frames_done_out,
  output logic [15:0]   frames_dropped_out
);
  localparam int TW = $clog2(DETECT_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DETECT = 2'd1,
    S_LAUNCH = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic          r_bank;
  logic          r_pending, r_pending_bank;
  logic [TW-1:0] r_tcnt;
  logic [11:0]   r_last_good, r_period;
  logic          r_detect_start, r_detect_bank, r_psola_start, r_busy;
  logic          r_overrun, r_timeout;
  logic [15:0]   r_frames_done, r_frames_dropped;
  logic          w_frame_done, w_tmo, w_in_range;
  logic          w_start_frame, w_take_period, w_timeout_evt;
  logic          w_done_evt, w_overrun_evt, w_defer;

  assign w_frame_done = sample_valid_in && (r_addr == AW'(WINDOW_SIZE - 1));
  // The detector wait begins after the start pulse, so the pulse cycle is not counted.
  assign w_tmo        = !r_detect_start && (r_tcnt == TW'(DETECT_TIMEOUT - 1));
  assign w_in_range   = (period_in >= 12'(MIN_PERIOD)) && (period_in <= 12'(MAX_PERIOD));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr <= '0;
      r_bank <= 1'b0;
    end else if (sample_valid_in) begin
      r_addr <= r_addr + AW'(1);
      if (w_frame_done) begin
        r_bank <= ~r_bank;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_frame = 1'b0;
    w_take_period = 1'b0;
    w_timeout_evt = 1'b0;
    w_done_evt    = 1'b0;
    w_overrun_evt = 1'b0;
    w_defer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_done || r_pending) begin
          w_start_frame = 1'b1;
          w_next        = S_DETECT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DETECT: begin
        w_overrun_evt = w_frame_done;
        if (period_valid_in) begin
          w_take_period = 1'b1;
          w_next        = S_LAUNCH;
        end else if (w_tmo) begin
          w_timeout_evt = 1'b1;
          w_next        = S_LAUNCH;
        end else begin
          w_next = S_DETECT;
        end
      end
      S_LAUNCH: begin
        w_overrun_evt = w_frame_done;
        w_next        = S_RUN;
      end
      S_RUN: begin
        if (psola_done_in) begin
          w_done_evt = 1'b1;
          w_defer    = w_frame_done;
          w_next     = S_IDLE;
        end else begin
          w_overrun_evt = w_frame_done;
          w_next        = S_RUN;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // A frame that completes exactly as the engine finishes is parked for one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pending      <= 1'b0;
      r_pending_bank <= 1'b0;
      r_detect_start <= 1'b0;
      r_detect_bank  <= 1'b0;
      r_tcnt         <= '0;
    end else begin
      r_detect_start <= w_start_frame;
      if (w_defer) begin
        r_pending      <= 1'b1;
        r_pending_bank <= r_bank;
      end else if (w_start_frame) begin
        r_pending <= 1'b0;
      end
      if (w_start_frame) begin
        r_detect_bank <= r_pending ? r_pending_bank : r_bank;
        r_tcnt        <= '0;
      end else if ((r_state == S_DETECT) && !r_detect_start) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_period         <= 12'(DEFAULT_PERIOD);
      r_last_good      <= 12'(DEFAULT_PERIOD);
      r_psola_start    <= 1'b0;
      r_busy           <= 1'b0;
      r_overrun        <= 1'b0;
      r_timeout        <= 1'b0;
      r_frames_done    <= 16'd0;
      r_frames_dropped <= 16'd0;
    end else begin
      r_psola_start <= w_take_period || w_timeout_evt;
      r_busy        <= (w_next != S_IDLE);
      if (w_take_period && w_in_range) begin
        r_period    <= period_in;
        r_last_good <= period_in;
      end else if (w_take_period || w_timeout_evt) begin
        r_period <= r_last_good;
      end
      if (w_timeout_evt) begin
        r_timeout <= 1'b1;
      end
      if (w_done_evt) begin
        r_frames_done <= r_frames_done + 16'd1;
      end
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
        if (r_frames_dropped != 16'hFFFF) begin
          r_frames_dropped <= r_frames_dropped + 16'd1;
        end
      end
    end
  end

  assign wr_en_out          = sample_valid_in;
  assign wr_bank_out        = r_bank;
  assign wr_addr_out        = r_addr;
  assign detect_start_out   = r_detect_start;
  assign detect_bank_out    = r_detect_bank;
  assign psola_start_out    = r_psola_start;
  assign psola_period_out   = r_period;
  assign busy_out           = r_busy;
  assign overrun_out        = r_overrun;
  assign timeout_out        = r_timeout;
  assign frames_done_out    = r_frames_done;
  assign frames_dropped_out = r_frames_dropped;

endmodule
